// File: rtl/baud_rate_gen_frac_pkg.sv
// Shared constants for the fractional baud-rate generator.
//   MIN_DIV          smallest integer divisor the counter can honour
//   DEF_OVERSAMPLE   o_tick periods per bit period
//   DEF_DIV_BITS     integer divisor width
//   DEF_FRAC_BITS    fractional divisor width (1/16 clock resolution)
//   DEF_DIV_INT/FRAC divisor after reset: 19200 baud x16 at 50 MHz
package baud_rate_gen_frac_pkg;

  localparam int MIN_DIV        = 2;
  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_DIV_BITS   = 16;
  localparam int DEF_FRAC_BITS  = 4;
  localparam int DEF_DIV_INT    = 163;
  localparam int DEF_DIV_FRAC   = 0;

endpackage

// File: rtl/baud_oversample_cnt.sv
// Oversample sub-counter: counts generator ticks modulo OVERSAMPLE and
// decodes the per-bit and mid-bit strobes that accompany a tick.
//   clock     system clock, rising edge
//   reset     asynchronous active-low reset
//   tick      generator tick event (same cycle the top registers o_tick)
//   clear     phase realign, sub-count back to 0, no strobes
//   bit_tick  registered, with the tick whose sub-count is OVERSAMPLE-1
//   mid_tick  registered, with the tick whose sub-count is OVERSAMPLE/2-1
module baud_oversample_cnt
  import baud_rate_gen_frac_pkg::*;
#(
  parameter int OVERSAMPLE = DEF_OVERSAMPLE
) (
  input  logic clock,
  input  logic reset,
  input  logic tick,
  input  logic clear,
  output logic bit_tick,
  output logic mid_tick
);

  localparam int SUB_W = $clog2(OVERSAMPLE);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OVERSAMPLE - 1);
  localparam logic [SUB_W-1:0] SUB_MID  = SUB_W'(OVERSAMPLE / 2 - 1);

  logic [SUB_W-1:0] sub;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sub      <= '0;
      bit_tick <= 1'b0;
      mid_tick <= 1'b0;
    end else begin
      // Strobes decode the sub-count before it advances, so the first
      // tick after a clear carries sub-count 0.
      bit_tick <= tick && !clear && (sub == SUB_LAST);
      mid_tick <= tick && !clear && (sub == SUB_MID);
      if (clear) begin
        sub <= '0;
      end else if (tick) begin
        sub <= (sub == SUB_LAST) ? '0 : sub + SUB_W'(1);
      end
    end
  end

endmodule

// File: rtl/baud_rate_gen_frac.sv
// Fractional baud-rate generator. Emits o_tick every
// DIV_INT + DIV_FRAC/2^FRAC_BITS clocks on average, plus bit/mid strobes.
//   clock          system clock, rising edge
//   reset          asynchronous active-low reset
//   i_enable       1 = run, 0 = freeze counters and suppress strobes
//   i_sync_clear   realign phase: clear counters, apply any pending divisor
//   i_div_wr       1-cycle strobe capturing i_div_int/i_div_frac as pending
//   i_div_int      new integer divisor (2..2^DIV_BITS-1)
//   i_div_frac     new fractional divisor
//   o_tick         oversample strobe, 1 cycle
//   o_bit_tick     with o_tick at the last sub-count of a bit period
//   o_mid_tick     with o_tick at the middle sub-count of a bit period
//   o_div_pending  a written divisor is waiting to be applied
//   o_div_err      1-cycle pulse: divisor write rejected (i_div_int < 2)
module baud_rate_gen_frac
  import baud_rate_gen_frac_pkg::*;
#(
  parameter int DIV_BITS     = DEF_DIV_BITS,
  parameter int FRAC_BITS    = DEF_FRAC_BITS,
  parameter int OVERSAMPLE   = DEF_OVERSAMPLE,
  parameter int DEF_DIV_INT  = baud_rate_gen_frac_pkg::DEF_DIV_INT,
  parameter int DEF_DIV_FRAC = baud_rate_gen_frac_pkg::DEF_DIV_FRAC
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 i_enable,
  input  logic                 i_sync_clear,
  input  logic                 i_div_wr,
  input  logic [DIV_BITS-1:0]  i_div_int,
  input  logic [FRAC_BITS-1:0] i_div_frac,
  output logic                 o_tick,
  output logic                 o_bit_tick,
  output logic                 o_mid_tick,
  output logic                 o_div_pending,
  output logic                 o_div_err
);

  logic [DIV_BITS-1:0]  count;
  logic [DIV_BITS-1:0]  div_int;
  logic [DIV_BITS-1:0]  pend_int;
  logic [FRAC_BITS-1:0] frac_acc;
  logic [FRAC_BITS-1:0] div_frac;
  logic [FRAC_BITS-1:0] pend_frac;
  logic                 carry;
  logic                 pend_valid;

  logic [DIV_BITS:0]    term_val;
  logic [FRAC_BITS:0]   frac_sum;
  logic                 terminal;
  logic                 tick_evt;
  logic                 div_ok;
  logic                 wr_ok;
  logic                 apply;

  always_comb begin
    term_val = {1'b0, div_int} - (DIV_BITS+1)'(1) + (DIV_BITS+1)'(carry);
    // >= rather than == so a divisor shrunk while frozen cannot be overrun.
    terminal = {1'b0, count} >= term_val;
    tick_evt = i_enable && !i_sync_clear && terminal;
    div_ok   = i_div_int >= DIV_BITS'(MIN_DIV);
    wr_ok    = i_div_wr && div_ok;
    // With the counter frozen there is no tick to wait for, so a pending
    // divisor is taken on the next clock instead.
    apply    = pend_valid && (i_sync_clear || !i_enable || terminal);
    frac_sum = {1'b0, frac_acc} + {1'b0, div_frac};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count      <= '0;
      frac_acc   <= '0;
      carry      <= 1'b0;
      div_int    <= DIV_BITS'(DEF_DIV_INT);
      div_frac   <= FRAC_BITS'(DEF_DIV_FRAC);
      pend_int   <= '0;
      pend_frac  <= '0;
      pend_valid <= 1'b0;
      o_tick     <= 1'b0;
      o_div_err  <= 1'b0;
    end else begin
      o_tick    <= tick_evt;
      o_div_err <= i_div_wr && !div_ok;

      if (i_sync_clear) begin
        count <= '0;
      end else if (i_enable) begin
        count <= terminal ? '0 : count + DIV_BITS'(1);
      end

      // The carry out of the accumulator stretches the next interval by one.
      if (apply || i_sync_clear) begin
        frac_acc <= '0;
        carry    <= 1'b0;
      end else if (tick_evt) begin
        {carry, frac_acc} <= frac_sum;
      end

      if (apply) begin
        div_int  <= pend_int;
        div_frac <= pend_frac;
      end

      // A write landing on the apply cycle stays pending behind the old one.
      if (wr_ok) begin
        pend_int   <= i_div_int;
        pend_frac  <= i_div_frac;
        pend_valid <= 1'b1;
      end else if (apply) begin
        pend_valid <= 1'b0;
      end
    end
  end

  assign o_div_pending = pend_valid;

  baud_oversample_cnt #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_oversample_cnt (
    .clock    (clock),
    .reset    (reset),
    .tick     (tick_evt),
    .clear    (i_sync_clear),
    .bit_tick (o_bit_tick),
    .mid_tick (o_mid_tick)
  );

endmodule

// File: tb/tb_baud_rate_gen_frac.sv
// Self-checking bench for baud_rate_gen_frac: directed hand sequences for
// the multi-cycle corners plus a table of divisor vectors.
module tb_baud_rate_gen_frac;

  logic        clock;
  logic        reset;
  logic        i_enable;
  logic        i_sync_clear;
  logic        i_div_wr;
  logic [15:0] i_div_int;
  logic [3:0]  i_div_frac;
  logic        o_tick;
  logic        o_bit_tick;
  logic        o_mid_tick;
  logic        o_div_pending;
  logic        o_div_err;

  int n_checks = 0;
  int n_fail   = 0;

  baud_rate_gen_frac dut (
    .clock         (clock),
    .reset         (reset),
    .i_enable      (i_enable),
    .i_sync_clear  (i_sync_clear),
    .i_div_wr      (i_div_wr),
    .i_div_int     (i_div_int),
    .i_div_frac    (i_div_frac),
    .o_tick        (o_tick),
    .o_bit_tick    (o_bit_tick),
    .o_mid_tick    (o_mid_tick),
    .o_div_pending (o_div_pending),
    .o_div_err     (o_div_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  typedef struct packed {
    logic [15:0]     div_int;
    logic [3:0]      div_frac;
    logic            exp_err;
    logic [4:0][7:0] exp_iv;
  } vec_t;

  vec_t vecs [7];

  function automatic logic [4:0][7:0] iv5(input int a, input int b, input int c,
                                          input int d, input int e);
    logic [4:0][7:0] r;
    r[0] = 8'(a); r[1] = 8'(b); r[2] = 8'(c); r[3] = 8'(d); r[4] = 8'(e);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Steps until o_tick is seen; n = clocks taken. Expiry counts as a failure.
  task automatic wait_tick(input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!o_tick && n < limit);
    if (!o_tick) begin
      n_checks++;
      n_fail++;
      $display("FAIL tick_timeout: no o_tick within %0d clocks", limit);
    end
  endtask

  task automatic write_div(input int di, input int df);
    i_div_wr   = 1'b1;
    i_div_int  = 16'(di);
    i_div_frac = 4'(df);
    step();
    i_div_wr   = 1'b0;
  endtask

  task automatic sync_pulse();
    i_sync_clear = 1'b1;
    step();
    i_sync_clear = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_tick"},    32'(o_tick),        0);
    check({name, "_bit"},     32'(o_bit_tick),    0);
    check({name, "_mid"},     32'(o_mid_tick),    0);
    check({name, "_pending"}, 32'(o_div_pending), 0);
    check({name, "_err"},     32'(o_div_err),     0);
  endtask

  initial begin
    int n;
    int tot;
    int seen;

    vecs[0] = '{16'd10, 4'd8,  1'b0, iv5(10, 10, 11, 10, 11)};
    vecs[1] = '{16'd5,  4'd0,  1'b0, iv5(5, 5, 5, 5, 5)};
    vecs[2] = '{16'd7,  4'd4,  1'b0, iv5(7, 7, 7, 7, 8)};
    vecs[3] = '{16'd1,  4'd3,  1'b1, iv5(7, 7, 7, 7, 8)};
    vecs[4] = '{16'd2,  4'd15, 1'b0, iv5(2, 2, 3, 3, 3)};
    vecs[5] = '{16'd0,  4'd0,  1'b1, iv5(2, 2, 3, 3, 3)};
    vecs[6] = '{16'd12, 4'd0,  1'b0, iv5(12, 12, 12, 12, 12)};

    reset        = 1'b0;
    i_enable     = 1'b0;
    i_sync_clear = 1'b0;
    i_div_wr     = 1'b0;
    i_div_int    = '0;
    i_div_frac   = '0;
    repeat (3) step();
    check_all_zero("reset");

    // Default divisor: 163-clock ticks, mid on 8th, bit on 16th.
    reset    = 1'b1;
    i_enable = 1'b1;
    for (int t = 1; t <= 17; t++) begin
      wait_tick(400, n);
      check("default_interval", n, 163);
      check("default_bit", 32'(o_bit_tick), 32'(t == 16));
      check("default_mid", 32'(o_mid_tick), 32'(t == 8));
    end

    // Freeze for 7 clocks at count 50.
    repeat (50) step();
    i_enable = 1'b0;
    seen = 0;
    repeat (7) begin
      step();
      if (o_tick) seen = 1;
    end
    check("frozen_no_tick", seen, 0);
    i_enable = 1'b1;
    wait_tick(400, n);
    check("freeze_interval", 57 + n, 170);

    // Rejected write: error pulse, period unchanged.
    repeat (20) step();
    write_div(1, 0);
    check("bad_wr_err", 32'(o_div_err), 1);
    check("bad_wr_pending", 32'(o_div_pending), 0);
    step();
    check("bad_wr_err_width", 32'(o_div_err), 0);
    wait_tick(400, n);
    check("bad_wr_interval", 22 + n, 163);

    // Mid-period write: old period completes, then 20.
    repeat (30) step();
    write_div(20, 0);
    check("wr20_pending", 32'(o_div_pending), 1);
    wait_tick(400, n);
    check("wr20_old_period", 31 + n, 163);
    check("wr20_pending_drop", 32'(o_div_pending), 0);
    wait_tick(400, n);
    check("wr20_new_period", n, 20);

    // Last write wins.
    repeat (5) step();
    write_div(30, 0);
    repeat (2) step();
    write_div(40, 0);
    wait_tick(400, n);
    check("lww_old_period", 9 + n, 20);
    check("lww_pending_drop", 32'(o_div_pending), 0);
    wait_tick(400, n);
    check("lww_new_period", n, 40);

    // Write landing on the apply cycle stays pending.
    repeat (10) step();
    write_div(50, 0);
    repeat (28) step();
    write_div(25, 0);
    check("apply_wr_tick", 32'(o_tick), 1);
    check("apply_wr_pending", 32'(o_div_pending), 1);
    wait_tick(400, n);
    check("apply_wr_first", n, 50);
    check("apply_wr_pending_drop", 32'(o_div_pending), 0);
    wait_tick(400, n);
    check("apply_wr_second", n, 25);

    // Sync clear at sub=5, mid-period.
    sync_pulse();
    check("sync0_no_tick", 32'(o_tick), 0);
    repeat (5) wait_tick(400, n);
    repeat (10) step();
    sync_pulse();
    check("sync_mid_no_tick", 32'(o_tick), 0);
    for (int k = 1; k <= 7; k++) begin
      wait_tick(400, n);
      check("sync_mid_interval", n, 25);
      check("sync_mid_mid", 32'(o_mid_tick), 0);
    end
    // Sync coinciding with the terminal count of what would be the 8th tick.
    repeat (24) step();
    sync_pulse();
    check("sync_term_no_tick", 32'(o_tick), 0);
    check("sync_term_no_mid", 32'(o_mid_tick), 0);
    for (int k = 1; k <= 8; k++) begin
      wait_tick(400, n);
      check("sync_term_interval", n, 25);
      check("sync_term_mid", 32'(o_mid_tick), 32'(k == 8));
    end

    // Reset while a write is pending.
    repeat (5) step();
    write_div(100, 0);
    check("rst_pending_set", 32'(o_div_pending), 1);
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("async_rst");
    step();
    step();
    reset = 1'b1;
    wait_tick(400, n);
    check("rst_default_div", n, 163);

    // Table vectors: write, apply by sync clear, measure five intervals.
    for (int v = 0; v < 7; v++) begin
      write_div(int'(vecs[v].div_int), int'(vecs[v].div_frac));
      check("vec_err", 32'(o_div_err), 32'(vecs[v].exp_err));
      check("vec_pending", 32'(o_div_pending), 32'(!vecs[v].exp_err));
      sync_pulse();
      check("vec_applied", 32'(o_div_pending), 0);
      for (int k = 0; k < 5; k++) begin
        wait_tick(400, n);
        check("vec_interval", n, 32'(vecs[v].exp_iv[k]));
      end
    end

    // 10 + 8/16: 32 consecutive intervals in steady state total 336 clocks.
    write_div(10, 8);
    sync_pulse();
    wait_tick(400, n);
    check("frac_first", n, 10);
    tot = 0;
    for (int k = 0; k < 32; k++) begin
      wait_tick(400, n);
      tot += n;
    end
    check("frac_32_ticks", tot, 336);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
